tlb_dual_port: RTL and testbench
================================

Name: tlb_dual_port

Overview:
- Fully associative, MIPS32-style joint TLB with two combinational lookup ports: instruction (port 0) and data (port 1).
- Also provides a write port for TLBWI/TLBWR, a read port for TLBR, and a probe for TLBP.
- Sits beside the CP0 register file. CP0 drives EntryHi/EntryLo0/EntryLo1/PageMask and the index, and consumes the translated addresses and exception flags.

Parameters:
- TLB_IDX_BITS, 5, index width; entry count is 2**TLB_IDX_BITS (32).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- o_p_EstallClear  in  1  pipeline-advance qualifier; a write commits only when this is 1
- we  in  1  write entry (TLBWI or TLBWR)
- index_i  in  TLB_IDX_BITS  entry to write, and entry to read
- mask_i  in  16  PageMask[28:13]
- entryhi_i  in  32  EntryHi: VPN2[31:13], ASID[7:0]; this ASID is also the current ASID for lookups and probe
- entrylo0_i, entrylo1_i  in  32 each  PFN[25:6], C[5:3], D[2], V[1], G[0]
- mask_o  out  16  stored mask of entry index_i
- entryhi_o  out  32  {VPN2, 5'b0, ASID}
- entrylo0_o, entrylo1_o  out  32 each  {6'b0, PFN, C, D, V, G}
- probe_index_o  out  32  bit31 = P (1 = no match); low TLB_IDX_BITS bits = matching index; all other bits 0
- va0  in  32  instruction virtual address
- pa0  out  32  instruction physical address
- exp_bus0  out  2  {miss, valid}
- c_com0  out  3  cache attribute for port 0
- va1, va1_bak  in  32 each  data virtual address candidates
- va1_choice  in  1  1 selects va1, 0 selects va1_bak
- pa1  out  32  data physical address
- exp_bus1  out  3  {miss, valid, notdirty}
- c_com1  out  3  cache attribute for port 1

Behaviour:
- Entry state: VPN2[18:0], ASID[7:0], G, mask[15:0], and per half PFN0/PFN1[19:0], C[2:0], D, V.
- Reset: every entry field is cleared to 0, so all entries are invalid and non-global.
- Write: on a clock edge with we=1 and o_p_EstallClear=1, entry index_i takes VPN2, ASID, mask, both halves, and G = G0 & G1. No other entry changes.
- Read: combinational from index_i. A write is visible to read and lookup on the next cycle.
- Match rule for an entry: VPN2 == va[31:13] AND (G OR ASID == entryhi_i[7:0]).
- Multiple matches: the lowest index wins, on every port.
- Lookup is combinational per port. On a hit:
  - half select = va[12]; the selected half supplies PFN, C, D, V;
  - pa = {PFN[19:0], va[11:0]};
  - miss = 0; valid = V; notdirty = ~D;
  - c_com = C.
- On a miss: miss = 1, valid = 0, notdirty = 0, c_com = 3'b000, pa = {20'b0, va[11:0]}.
- Port 1 uses va1_choice ? va1 : va1_bak as its virtual address.
- Exceptions are not qualified here. The caller gates the flags with its "mapped segment" and "store" conditions.
- Probe: combinational, using entryhi_i VPN2 and ASID with the same match rule.
  - Hit: {1'b0, 26'b0, index}.
  - No hit: 32'h8000_0000.
- Simultaneous write and lookup of the same entry in one cycle: the lookup returns pre-write contents.
- Default build: mask is stored and read back verbatim but ignored in matching, so translation is 4 KB pages only.

Optional Feature:
- Macro: TLB_PAGEMASK_EN.
- When defined:
  - VPN2 bit va[13+i] is excluded from the compare where mask[i]=1.
  - Half-select bit becomes va[12+k], where k = popcount(mask); legal masks are contiguous low-order pairs, e.g. 16'h0003 gives 16 KB pages and va[14].
  - pa takes va bits below 12+k, and PFN supplies the upper bits.
- When undefined: 4 KB-only behaviour as above.

Test Plan:
- Reset, then look up va0=32'h0040_0000 -> exp_bus0=2'b10, pa0=32'h0000_0000, probe_index_o=32'h8000_0000.
- Write idx 3 with EntryHi=32'h0040_0005, Lo0=32'h0000_1016 (PFN 0x40, C=2, D=1, V=1, G=0), Lo1=32'h0000_1057 (PFN 0x41, C=2, D=1, V=1, G=1), qualifier=1. With ASID 5 and va0=32'h0040_0123 -> pa0=32'h0004_0123, exp_bus0=2'b01, c_com0=2.
- Same entry, va1=32'h0040_1ABC, va1_choice=1, ASID changed to 7 -> hit because G=G0&G1=0? No: G=0, so the lookup misses. Restore ASID 5 -> pa1=32'h0004_1ABC, exp_bus1=3'b010.
- Write with o_p_EstallClear=0 -> entry unchanged; reading idx 3 returns the prior contents.
- va1_choice=0 with va1_bak=32'h0040_0010 -> translation uses va1_bak; an entry with D=0 gives exp_bus1[0]=1.
- Duplicate VPN2 in idx 2 and idx 9, then probe -> probe_index_o=32'h0000_0002; read of idx 9 returns entryhi_o with bits[12:8]=0.

Source files
------------

// File: rtl/tlb_dual_port.sv
// Fully associative MIPS32-style joint TLB with instruction and data lookup ports,
// plus TLBWI/TLBWR write, TLBR read and TLBP probe. Define TLB_PAGEMASK_EN for variable page sizes.
module tlb_dual_port #(
    parameter int TLB_IDX_BITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    o_p_EstallClear,
    input  logic                    we,
    input  logic [TLB_IDX_BITS-1:0] index_i,
    input  logic [15:0]             mask_i,
    input  logic [31:0]             entryhi_i,
    input  logic [31:0]             entrylo0_i,
    input  logic [31:0]             entrylo1_i,
    output logic [15:0]             mask_o,
    output logic [31:0]             entryhi_o,
    output logic [31:0]             entrylo0_o,
    output logic [31:0]             entrylo1_o,
    output logic [31:0]             probe_index_o,
    input  logic [31:0]             va0,
    output logic [31:0]             pa0,
    output logic [1:0]              exp_bus0,
    output logic [2:0]              c_com0,
    input  logic [31:0]             va1,
    input  logic [31:0]             va1_bak,
    input  logic                    va1_choice,
    output logic [31:0]             pa1,
    output logic [2:0]              exp_bus1,
    output logic [2:0]              c_com1
);
    localparam int N = 1 << TLB_IDX_BITS;

    logic [18:0] vpn2_q [N];
    logic [7:0]  asid_q [N];
    logic        g_q    [N];
    logic [15:0] mask_q [N];
    logic [19:0] pfn0_q [N];
    logic [19:0] pfn1_q [N];
    logic [2:0]  c0_q   [N];
    logic [2:0]  c1_q   [N];
    logic        d0_q   [N];
    logic        d1_q   [N];
    logic        v0_q   [N];
    logic        v1_q   [N];

    // Entry is global only when both halves were written with G set
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                vpn2_q[i] <= '0;
                asid_q[i] <= '0;
                g_q[i]    <= 1'b0;
                mask_q[i] <= '0;
                pfn0_q[i] <= '0;
                pfn1_q[i] <= '0;
                c0_q[i]   <= '0;
                c1_q[i]   <= '0;
                d0_q[i]   <= 1'b0;
                d1_q[i]   <= 1'b0;
                v0_q[i]   <= 1'b0;
                v1_q[i]   <= 1'b0;
            end
        end else if (we && o_p_EstallClear) begin
            vpn2_q[index_i] <= entryhi_i[31:13];
            asid_q[index_i] <= entryhi_i[7:0];
            g_q[index_i]    <= entrylo0_i[0] & entrylo1_i[0];
            mask_q[index_i] <= mask_i;
            pfn0_q[index_i] <= entrylo0_i[25:6];
            pfn1_q[index_i] <= entrylo1_i[25:6];
            c0_q[index_i]   <= entrylo0_i[5:3];
            c1_q[index_i]   <= entrylo1_i[5:3];
            d0_q[index_i]   <= entrylo0_i[2];
            d1_q[index_i]   <= entrylo1_i[2];
            v0_q[index_i]   <= entrylo0_i[1];
            v1_q[index_i]   <= entrylo1_i[1];
        end
    end

    assign mask_o     = mask_q[index_i];
    assign entryhi_o  = {vpn2_q[index_i], 5'b0, asid_q[index_i]};
    assign entrylo0_o = {6'b0, pfn0_q[index_i], c0_q[index_i], d0_q[index_i], v0_q[index_i], g_q[index_i]};
    assign entrylo1_o = {6'b0, pfn1_q[index_i], c1_q[index_i], d1_q[index_i], v1_q[index_i], g_q[index_i]};

    logic [31:0] va1_sel;
    logic [7:0]  cur_asid;
    logic [N-1:0] hit_vec0, hit_vec1, hit_vecp;

    assign va1_sel  = va1_choice ? va1 : va1_bak;
    assign cur_asid = entryhi_i[7:0];

    for (genvar i = 0; i < N; i++) begin : g_entry
        logic [18:0] care;
        logic        asid_ok;
`ifdef TLB_PAGEMASK_EN
        assign care = {3'b111, ~mask_q[i]};
`else
        assign care = '1;
`endif
        assign asid_ok     = g_q[i] || (asid_q[i] == cur_asid);
        assign hit_vec0[i] = asid_ok && (((vpn2_q[i] ^ va0[31:13]) & care) == '0);
        assign hit_vec1[i] = asid_ok && (((vpn2_q[i] ^ va1_sel[31:13]) & care) == '0);
        assign hit_vecp[i] = asid_ok && (((vpn2_q[i] ^ entryhi_i[31:13]) & care) == '0);
    end

    // Lowest matching index wins when software has left duplicate entries
    function automatic logic [TLB_IDX_BITS-1:0] first_set(input logic [N-1:0] v);
        logic [TLB_IDX_BITS-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = i[TLB_IDX_BITS-1:0];
        end
        return r;
    endfunction

    logic [TLB_IDX_BITS-1:0] idx0, idx1, idxp;
    logic hit0, hit1, hitp;

    assign idx0 = first_set(hit_vec0);
    assign idx1 = first_set(hit_vec1);
    assign idxp = first_set(hit_vecp);
    assign hit0 = |hit_vec0;
    assign hit1 = |hit_vec1;
    assign hitp = |hit_vecp;

`ifdef TLB_PAGEMASK_EN
    function automatic logic [31:0] low_mask(input logic [15:0] m);
        logic [4:0] k;
        k = '0;
        for (int i = 0; i < 16; i++) k = k + {4'b0, m[i]};
        return (32'd1 << (5'd12 + k)) - 32'd1;
    endfunction
`endif

    // lm marks the page-offset bits; the bit just above it selects the even/odd half
    logic [31:0] lm0, lm1;
`ifdef TLB_PAGEMASK_EN
    assign lm0 = low_mask(mask_q[idx0]);
    assign lm1 = low_mask(mask_q[idx1]);
`else
    assign lm0 = 32'h0000_0FFF;
    assign lm1 = 32'h0000_0FFF;
`endif

    logic        half0, half1;
    logic [19:0] pfn_s0, pfn_s1;
    logic [2:0]  c_s0, c_s1;
    logic        v_s0, v_s1, d_s1;

    assign half0  = |(va0 & (lm0 + 32'd1));
    assign half1  = |(va1_sel & (lm1 + 32'd1));
    assign pfn_s0 = half0 ? pfn1_q[idx0] : pfn0_q[idx0];
    assign c_s0   = half0 ? c1_q[idx0]   : c0_q[idx0];
    assign v_s0   = half0 ? v1_q[idx0]   : v0_q[idx0];
    assign pfn_s1 = half1 ? pfn1_q[idx1] : pfn0_q[idx1];
    assign c_s1   = half1 ? c1_q[idx1]   : c0_q[idx1];
    assign v_s1   = half1 ? v1_q[idx1]   : v0_q[idx1];
    assign d_s1   = half1 ? d1_q[idx1]   : d0_q[idx1];

    assign pa0      = hit0 ? (({pfn_s0, 12'b0} & ~lm0) | (va0 & lm0)) : {20'b0, va0[11:0]};
    assign exp_bus0 = {~hit0, hit0 & v_s0};
    assign c_com0   = hit0 ? c_s0 : 3'b000;

    assign pa1      = hit1 ? (({pfn_s1, 12'b0} & ~lm1) | (va1_sel & lm1)) : {20'b0, va1_sel[11:0]};
    assign exp_bus1 = {~hit1, hit1 & v_s1, hit1 & ~d_s1};
    assign c_com1   = hit1 ? c_s1 : 3'b000;

    always_comb begin
        probe_index_o = 32'h8000_0000;
        if (hitp) begin
            probe_index_o = '0;
            probe_index_o[TLB_IDX_BITS-1:0] = idxp;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26]};

endmodule

// File: tb/tb_tlb_dual_port.sv
// Self-checking bench for tlb_dual_port: table of lookup vectors checked through a
// scoreboard queue, plus read-back and same-cycle write/lookup sequences.
module tb_tlb_dual_port;
    logic        clk = 1'b0;
    logic        rst;
    logic        o_p_EstallClear;
    logic        we;
    logic [4:0]  index_i;
    logic [15:0] mask_i;
    logic [31:0] entryhi_i, entrylo0_i, entrylo1_i;
    logic [15:0] mask_o;
    logic [31:0] entryhi_o, entrylo0_o, entrylo1_o, probe_index_o;
    logic [31:0] va0, pa0, va1, va1_bak, pa1;
    logic [1:0]  exp_bus0;
    logic [2:0]  c_com0, exp_bus1, c_com1;
    logic        va1_choice;

    int asserts  = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi, va0, va1, bak;
        logic        ch;
        logic [31:0] pa0;
        logic [1:0]  eb0;
        logic [2:0]  c0;
        logic [31:0] pa1;
        logic [2:0]  eb1;
        logic [2:0]  c1;
        logic [31:0] probe;
    } vec_t;

    vec_t vecs[8];
    vec_t exp_q[$];

    tlb_dual_port dut (
        .clk(clk), .rst(rst), .o_p_EstallClear(o_p_EstallClear), .we(we),
        .index_i(index_i), .mask_i(mask_i), .entryhi_i(entryhi_i),
        .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i),
        .mask_o(mask_o), .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o),
        .entrylo1_o(entrylo1_o), .probe_index_o(probe_index_o),
        .va0(va0), .pa0(pa0), .exp_bus0(exp_bus0), .c_com0(c_com0),
        .va1(va1), .va1_bak(va1_bak), .va1_choice(va1_choice),
        .pa1(pa1), .exp_bus1(exp_bus1), .c_com1(c_com1)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] hi, v0, v1, bak, input logic ch,
                                input logic [31:0] p0, input logic [1:0] e0, input logic [2:0] c0,
                                input logic [31:0] p1, input logic [2:0] e1, input logic [2:0] c1,
                                input logic [31:0] pr);
        vec_t v;
        v.hi = hi; v.va0 = v0; v.va1 = v1; v.bak = bak; v.ch = ch;
        v.pa0 = p0; v.eb0 = e0; v.c0 = c0; v.pa1 = p1; v.eb1 = e1; v.c1 = c1; v.probe = pr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        asserts++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        entryhi_i  = v.hi;
        va0        = v.va0;
        va1        = v.va1;
        va1_bak    = v.bak;
        va1_choice = v.ch;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, " pa0"}, pa0, e.pa0);
            check({tag, " exp_bus0"}, {30'b0, exp_bus0}, {30'b0, e.eb0});
            check({tag, " c_com0"}, {29'b0, c_com0}, {29'b0, e.c0});
            check({tag, " pa1"}, pa1, e.pa1);
            check({tag, " exp_bus1"}, {29'b0, exp_bus1}, {29'b0, e.eb1});
            check({tag, " c_com1"}, {29'b0, c_com1}, {29'b0, e.c1});
            check({tag, " probe"}, probe_index_o, e.probe);
        end
    endtask

    task automatic runVec(input int n);
        applyStimulus(vecs[n]);
        checkOutput($sformatf("vec%0d", n));
    endtask

    task automatic writeEntry(input logic [4:0] idx, input logic [31:0] hi, lo0, lo1,
                              input logic [15:0] m, input logic qual);
        @(posedge clk);
        #1;
        index_i = idx; entryhi_i = hi; entrylo0_i = lo0; entrylo1_i = lo1;
        mask_i = m; o_p_EstallClear = qual; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; o_p_EstallClear = 1'b1;
    endtask

    task automatic checkRead(input logic [4:0] idx, input logic [31:0] ehi, elo0, elo1,
                             input logic [15:0] emask);
        @(posedge clk);
        #1;
        index_i = idx;
        @(negedge clk);
        check($sformatf("read%0d entryhi", idx), entryhi_o, ehi);
        check($sformatf("read%0d entrylo0", idx), entrylo0_o, elo0);
        check($sformatf("read%0d entrylo1", idx), entrylo1_o, elo1);
        check($sformatf("read%0d mask", idx), {16'b0, mask_o}, {16'b0, emask});
    endtask

    initial begin
        vecs[0] = mk(32'h0040_0000, 32'h0040_0000, 32'h0040_1000, 32'h0, 1'b1,
                     32'h0, 2'b10, 3'd0, 32'h0, 3'b100, 3'd0, 32'h8000_0000);
        vecs[1] = mk(32'h0040_0005, 32'h0040_0123, 32'h0040_1ABC, 32'h0040_0010, 1'b1,
                     32'h0004_0123, 2'b01, 3'd2, 32'h0004_1ABC, 3'b010, 3'd2, 32'h3);
        vecs[2] = mk(32'h0040_0007, 32'h0040_0123, 32'h0040_1ABC, 32'h0040_0010, 1'b1,
                     32'h0000_0123, 2'b10, 3'd0, 32'h0000_0ABC, 3'b100, 3'd0, 32'h8000_0000);
        vecs[3] = mk(32'h0040_0005, 32'h0040_1FFF, 32'h0040_1ABC, 32'h0040_0010, 1'b0,
                     32'h0004_1FFF, 2'b01, 3'd2, 32'h0004_0010, 3'b010, 3'd2, 32'h3);
        vecs[4] = mk(32'h0080_0005, 32'h0080_1234, 32'h0040_1ABC, 32'h0080_0010, 1'b0,
                     32'h0012_4234, 2'b00, 3'd0, 32'h0012_3010, 3'b011, 3'd3, 32'h4);
        vecs[5] = mk(32'h0100_0099, 32'h0100_0ABC, 32'h0100_1000, 32'h0, 1'b1,
                     32'h0020_0ABC, 2'b01, 3'd5, 32'h0020_1000, 3'b010, 3'd5, 32'h7);
        vecs[6] = mk(32'h00C0_0005, 32'h00C0_0044, 32'h00C0_1008, 32'h0, 1'b1,
                     32'h0031_0044, 2'b01, 3'd1, 32'h0031_1008, 3'b010, 3'd1, 32'h2);
        vecs[7] = mk(32'h0040_0005, 32'h0040_0123, 32'h0040_1ABC, 32'h0040_0010, 1'b1,
                     32'h0008_0123, 2'b01, 3'd2, 32'h0008_1ABC, 3'b010, 3'd2, 32'h3);

        rst = 1'b1; o_p_EstallClear = 1'b1; we = 1'b0; index_i = '0; mask_i = '0;
        entryhi_i = '0; entrylo0_i = '0; entrylo1_i = '0;
        va0 = '0; va1 = '0; va1_bak = '0; va1_choice = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkRead(5'd3, 32'h0, 32'h0, 32'h0, 16'h0);
        runVec(0);

        writeEntry(5'd3, 32'h0040_0005, 32'h0000_1016, 32'h0000_1057, 16'h0, 1'b1);
        checkRead(5'd3, 32'h0040_0005, 32'h0000_1016, 32'h0000_1056, 16'h0);
        for (int n = 1; n <= 3; n++) runVec(n);

        writeEntry(5'd3, 32'h1234_5006, 32'hFFFF_FFFF, 32'h0, 16'hFFFF, 1'b0);
        checkRead(5'd3, 32'h0040_0005, 32'h0000_1016, 32'h0000_1056, 16'h0);
        runVec(1);

        writeEntry(5'd4, 32'h0080_0005, 32'h0000_48DA, 32'h0000_4904, 16'h0, 1'b1);
        writeEntry(5'd7, 32'h0100_0011, 32'h0000_802F, 32'h0000_806F, 16'h0, 1'b1);
        writeEntry(5'd9, 32'h00C0_1F05, 32'h0000_C00E, 32'h0000_C04E, 16'h0003, 1'b1);
        writeEntry(5'd2, 32'h00C0_0005, 32'h0000_C40E, 32'h0000_C44E, 16'h0, 1'b1);
        for (int n = 4; n <= 6; n++) runVec(n);
        checkRead(5'd9, 32'h00C0_0005, 32'h0000_C00E, 32'h0000_C04E, 16'h0003);

        // Same-cycle rewrite of entry 3: lookup before the edge sees old contents
        applyStimulus(vecs[1]);
        index_i = 5'd3; entrylo0_i = 32'h0000_2016; entrylo1_i = 32'h0000_2057;
        mask_i = 16'h0; o_p_EstallClear = 1'b1; we = 1'b1;
        checkOutput("simul_pre");
        applyStimulus(vecs[7]);
        we = 1'b0;
        checkOutput("simul_post");
        checkRead(5'd3, 32'h0040_0005, 32'h0000_2016, 32'h0000_2056, 16'h0);

        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checkRead(5'd3, 32'h0, 32'h0, 32'h0, 16'h0);
        runVec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
